// File: rtl/tlb_xlate_arb_pkg.sv
// Shared types for the fetch/load-store translation arbiter: FSM encoding,
// source IDs, exception codes and the lookup-result priority resolver.
package tlb_xlate_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic SRC_IF  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  localparam logic [1:0] ECODE_NONE   = 2'd0;
  localparam logic [1:0] ECODE_REFILL = 2'd1;

  typedef struct packed {
    logic [31:0] paddr;
    logic [1:0]  mat;
    logic [1:0]  ecode;
  } xl_rsp_t;

  // Direct-address mode beats DMW, DMW beats TLB, a full miss is a refill.
  function automatic xl_rsp_t xl_resolve(
    input logic        da,
    input logic [1:0]  dmat,
    input logic [31:0] vaddr,
    input logic        dmw_hit,
    input logic [31:0] dmw_paddr,
    input logic [1:0]  dmw_mat,
    input logic        tlb_hit,
    input logic [31:0] tlb_paddr,
    input logic [1:0]  tlb_mat
  );
    xl_rsp_t r;
    if (da)           r = '{paddr: vaddr,     mat: dmat,    ecode: ECODE_NONE};
    else if (dmw_hit) r = '{paddr: dmw_paddr, mat: dmw_mat, ecode: ECODE_NONE};
    else if (tlb_hit) r = '{paddr: tlb_paddr, mat: tlb_mat, ecode: ECODE_NONE};
    else              r = '{paddr: 32'd0,     mat: 2'd0,    ecode: ECODE_REFILL};
    return r;
  endfunction

endpackage

// File: rtl/xlate_arb_pick.sv
// Two-way arbiter: grant[SRC_IF]/grant[SRC_MEM], one-hot. ptr holds the
// source granted last; the other source wins a tie.
module xlate_arb_pick
  import tlb_xlate_arb_pkg::*;
(
  input  logic       if_valid,
  input  logic       mem_valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant          = 2'b00;
    grant[SRC_MEM] = mem_valid && !(if_valid && ptr == SRC_MEM);
    grant[SRC_IF]  = if_valid && !(mem_valid && ptr == SRC_IF);
  end

endmodule

// File: rtl/tlb_xlate_arb.sv
// Arbitrates fetch and load/store translation requests onto one shared
// DMW/TLB lookup port. Define XLATE_ARB_RR_EN for round-robin, else MEM-first.
module tlb_xlate_arb
  import tlb_xlate_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_vaddr,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [31:0] mem_vaddr,
  input  logic [1:0]  plv,
  input  logic        crmd_da,
  input  logic [1:0]  crmd_dmat,
  input  logic        flush,
  output logic [31:0] xl_vaddr,
  output logic [1:0]  xl_plv,
  input  logic        xl_dmw_hit,
  input  logic [31:0] xl_dmw_paddr,
  input  logic [1:0]  xl_dmw_mat,
  input  logic        xl_tlb_hit,
  input  logic [31:0] xl_tlb_paddr,
  input  logic [1:0]  xl_tlb_mat,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic        mem_rsp_valid,
  input  logic        mem_rsp_ready,
  output logic [31:0] rsp_paddr,
  output logic [1:0]  rsp_mat,
  output logic [1:0]  rsp_ecode
);

  state_t      state, nxt;
  logic [31:0] vaddr_q;
  logic        src_q;
  logic        ptr;
  logic [1:0]  gnt;
  logic        idle_rdy, fire, rsp_rdy_sel;
  xl_rsp_t     rsp_q, lk;

  // Ready is gated by rstn so it reads 0 the instant reset asserts.
  assign idle_rdy    = rstn && (state == ST_IDLE) && !flush;
  assign fire        = idle_rdy && (gnt != 2'b00);
  assign rsp_rdy_sel = (src_q == SRC_MEM) ? mem_rsp_ready : if_rsp_ready;

  xlate_arb_pick u_pick (
    .if_valid  (if_req_valid),
    .mem_valid (mem_req_valid),
    .ptr       (ptr),
    .grant     (gnt)
  );

`ifdef XLATE_ARB_RR_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)     ptr <= SRC_IF;
    else if (fire) ptr <= gnt[SRC_MEM];
`else
  assign ptr = SRC_IF;
`endif

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= ST_IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (fire) nxt = ST_LOOKUP;
      ST_LOOKUP: nxt = ST_RESP;
      ST_RESP:   if (rsp_rdy_sel) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
    if (flush) nxt = ST_IDLE;
  end

  always_comb begin
    if_req_ready  = idle_rdy;
    mem_req_ready = idle_rdy;
    xl_vaddr      = (state == ST_LOOKUP) ? vaddr_q : 32'd0;
    xl_plv        = (state == ST_LOOKUP) ? plv : 2'd0;
    if_rsp_valid  = (state == ST_RESP) && (src_q == SRC_IF);
    mem_rsp_valid = (state == ST_RESP) && (src_q == SRC_MEM);
    rsp_paddr     = rsp_q.paddr;
    rsp_mat       = rsp_q.mat;
    rsp_ecode     = rsp_q.ecode;
  end

  // crmd_da and the lookup result are sampled on the LOOKUP->RESP edge.
  assign lk = xl_resolve(crmd_da, crmd_dmat, vaddr_q,
                         xl_dmw_hit, xl_dmw_paddr, xl_dmw_mat,
                         xl_tlb_hit, xl_tlb_paddr, xl_tlb_mat);

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vaddr_q <= 32'd0;
      src_q   <= SRC_IF;
      rsp_q   <= '0;
    end else begin
      if (fire) begin
        vaddr_q <= gnt[SRC_MEM] ? mem_vaddr : if_vaddr;
        src_q   <= gnt[SRC_MEM];
      end
      if (state == ST_LOOKUP && !flush) rsp_q <= lk;
    end

endmodule

// File: tb/tb_tlb_xlate_arb.sv
// Directed bench for tlb_xlate_arb; follows XLATE_ARB_RR_EN for the
// arbitration-order expectations.
module tb_tlb_xlate_arb;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        if_req_valid = 0, if_req_ready, mem_req_valid = 0, mem_req_ready;
  logic [31:0] if_vaddr = 0, mem_vaddr = 0, xl_vaddr;
  logic [1:0]  plv = 0, crmd_dmat = 0, xl_plv;
  logic        crmd_da = 0, flush = 0;
  logic        xl_dmw_hit = 0, xl_tlb_hit = 0;
  logic [31:0] xl_dmw_paddr = 0, xl_tlb_paddr = 0, rsp_paddr;
  logic [1:0]  xl_dmw_mat = 0, xl_tlb_mat = 0, rsp_mat, rsp_ecode;
  logic        if_rsp_valid, if_rsp_ready = 1, mem_rsp_valid, mem_rsp_ready = 1;

  int vectors = 0, miscompares = 0;

`ifdef XLATE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  tlb_xlate_arb dut (
    .clk(clk), .rstn(rstn),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_vaddr(if_vaddr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_vaddr(mem_vaddr),
    .plv(plv), .crmd_da(crmd_da), .crmd_dmat(crmd_dmat), .flush(flush),
    .xl_vaddr(xl_vaddr), .xl_plv(xl_plv),
    .xl_dmw_hit(xl_dmw_hit), .xl_dmw_paddr(xl_dmw_paddr), .xl_dmw_mat(xl_dmw_mat),
    .xl_tlb_hit(xl_tlb_hit), .xl_tlb_paddr(xl_tlb_paddr), .xl_tlb_mat(xl_tlb_mat),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .rsp_paddr(rsp_paddr), .rsp_mat(rsp_mat), .rsp_ecode(rsp_ecode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, take the grant edge, drop valid; returns in LOOKUP.
  task automatic issue(input bit mem, input logic [31:0] va);
    if (mem) begin mem_req_valid = 1; mem_vaddr = va; end
    else     begin if_req_valid  = 1; if_vaddr  = va; end
    #1;
    chk("req_ready_idle", mem ? mem_req_ready : if_req_ready, 1);
    step();
    mem_req_valid = 0;
    if_req_valid  = 0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_if_ready", if_req_ready, 0);
    chk("rst_mem_ready", mem_req_ready, 0);
    chk("rst_xl_vaddr", xl_vaddr, 0);
    chk("rst_rsp_valid", {if_rsp_valid, mem_rsp_valid}, 0);
    chk("rst_payload", {rsp_paddr[29:0], rsp_mat}, 0);
    #10 rstn = 1;
    step();

    // direct-address fetch, N+2 latency
    crmd_da = 1; crmd_dmat = 2'd1; plv = 2'd3;
    issue(0, 32'h1C00_0000);
    chk("lk_xl_vaddr", xl_vaddr, 32'h1C00_0000);
    chk("lk_xl_plv", xl_plv, 3);
    chk("lk_ready", if_req_ready, 0);
    chk("lk_no_rsp", if_rsp_valid, 0);
    step();
    chk("da_if_rsp", if_rsp_valid, 1);
    chk("da_mem_rsp", mem_rsp_valid, 0);
    chk("da_paddr", rsp_paddr, 32'h1C00_0000);
    chk("da_mat", rsp_mat, 1);
    chk("da_ecode", rsp_ecode, 0);
    chk("resp_xl_vaddr", xl_vaddr, 0);
    step();
    chk("da_back_idle", if_req_ready, 1);
    chk("da_rsp_drop", if_rsp_valid, 0);

    // DMW beats TLB; stall response 5 cycles
    crmd_da = 0;
    xl_dmw_hit = 1; xl_dmw_paddr = 32'h0000_1234; xl_dmw_mat = 2'd1;
    xl_tlb_hit = 1; xl_tlb_paddr = 32'hABCD_0000; xl_tlb_mat = 2'd2;
    mem_rsp_ready = 0;
    issue(1, 32'h8000_0000);
    step();
    xl_dmw_paddr = 32'hDEAD_BEEF; xl_dmw_mat = 2'd3;
    if_req_valid = 1; if_vaddr = 32'h0000_4000;
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_rsp", mem_rsp_valid, 1);
      chk("stall_paddr", rsp_paddr, 32'h0000_1234);
      chk("stall_mat", rsp_mat, 1);
      chk("stall_ready", {if_req_ready, mem_req_ready}, 0);
      step();
    end
    if_req_valid = 0;
    mem_rsp_ready = 1;
    step();
    chk("stall_idle", mem_req_ready, 1);
    chk("stall_rsp_drop", mem_rsp_valid, 0);

    // TLB-only hit
    xl_dmw_hit = 0;
    issue(1, 32'h4000_0000);
    step();
    chk("tlb_paddr", rsp_paddr, 32'hABCD_0000);
    chk("tlb_mat", rsp_mat, 2);
    chk("tlb_ecode", rsp_ecode, 0);
    step();

    // full miss -> refill
    xl_tlb_hit = 0;
    issue(1, 32'h4000_1000);
    step();
    chk("miss_ecode", rsp_ecode, 1);
    chk("miss_paddr", rsp_paddr, 0);
    chk("miss_mat", rsp_mat, 0);
    step();

    // crmd_da raised during LOOKUP takes effect
    crmd_dmat = 2'd2;
    issue(1, 32'h0BAD_F00D);
    crmd_da = 1;
    step();
    chk("late_da_paddr", rsp_paddr, 32'h0BAD_F00D);
    chk("late_da_ecode", rsp_ecode, 0);
    step();

    // flush during LOOKUP
    issue(1, 32'h1111_0000);
    flush = 1; #1;
    chk("flush_ready", mem_req_ready, 0);
    step();
    flush = 0; #1;
    chk("flush_idle", mem_req_ready, 1);
    chk("flush_no_rsp", mem_rsp_valid, 0);
    step();
    chk("flush_no_rsp2", mem_rsp_valid, 0);

    // flush coincident with a request cancels the grant
    if_req_valid = 1; if_vaddr = 32'h2222_0000; flush = 1; #1;
    chk("flush_grant_ready", if_req_ready, 0);
    step();
    if_req_valid = 0; flush = 0; #1;
    chk("flush_grant_cancel", xl_vaddr, 0);
    chk("flush_grant_idle", if_req_ready, 1);
    step();
    chk("flush_grant_no_rsp", if_rsp_valid, 0);

    // reset during RESP
    issue(0, 32'h3333_0000);
    step();
    chk("pre_rst_rsp", if_rsp_valid, 1);
    rstn = 0; #1;
    chk("rst_mid_rsp", if_rsp_valid, 0);
    chk("rst_mid_payload", rsp_paddr, 0);
    chk("rst_mid_ready", if_req_ready, 0);
    #2 rstn = 1;
    step();
    step();
    chk("post_rst_no_rsp", {if_rsp_valid, mem_rsp_valid}, 0);
    issue(0, 32'h4444_0000);
    step();
    chk("post_rst_rsp", if_rsp_valid, 1);
    chk("post_rst_paddr", rsp_paddr, 32'h4444_0000);
    step();

    // both sources valid every cycle; last grant was IF
    if_req_valid = 1; if_vaddr = 32'h0000_1000;
    mem_req_valid = 1; mem_vaddr = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      automatic bit exp_mem = RR ? (i % 2 == 0) : 1'b1;
      #1;
      chk("arb_idle", mem_req_ready, 1);
      step();
      step();
      chk("arb_mem_rsp", mem_rsp_valid, exp_mem);
      chk("arb_if_rsp", if_rsp_valid, !exp_mem);
      chk("arb_paddr", rsp_paddr, exp_mem ? 32'h0000_2000 : 32'h0000_1000);
      step();
    end
    if_req_valid = 0; mem_req_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
